// File: rtl/pc_next_pkg.sv
// Shared encodings for the next-PC unit: control-flow classes driven by the
// execute stage and the sequential PC increment.
package pc_next_pkg;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_JAL  = 4'd1;
    localparam logic [3:0] BR_JALR = 4'd2;
    localparam logic [3:0] BR_BEQ  = 4'd4;
    localparam logic [3:0] BR_BNE  = 4'd5;
    localparam logic [3:0] BR_BLT  = 4'd6;
    localparam logic [3:0] BR_BGE  = 4'd7;
    localparam logic [3:0] BR_BLTU = 4'd8;
    localparam logic [3:0] BR_BGEU = 4'd9;

    localparam int unsigned PC_INC = 32'd4;

endpackage

// File: rtl/pc_next_unit_br_resolve.sv
// Combinational branch/jump resolution: decides whether the executing
// instruction redirects, computes its target and flags a misaligned target.
module br_resolve
    import pc_next_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic            ex_valid_i,
    input  logic [3:0]      ex_br_op_i,
    input  logic            ex_zero_i,
    input  logic            ex_less_i,
    input  logic            ex_less_u_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    output logic            redirect_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] target_o
);

    logic            taken_s;
    logic            bad_align_s;
    logic [XLEN-1:0] jalr_sum_s;

    // Taken decision per control-flow class; unknown codes never redirect
    always_comb begin
        taken_s = 1'b0;
        case (ex_br_op_i)
            BR_JAL, BR_JALR: taken_s = 1'b1;
            BR_BEQ:          taken_s = ex_zero_i;
            BR_BNE:          taken_s = ~ex_zero_i;
            BR_BLT:          taken_s = ex_less_i;
            BR_BGE:          taken_s = ~ex_less_i;
            BR_BLTU:         taken_s = ex_less_u_i;
            BR_BGEU:         taken_s = ~ex_less_u_i;
            default:         taken_s = 1'b0;
        endcase
    end

    // Target address: register-relative with bit0 cleared for jalr, PC-relative otherwise
    always_comb begin
        jalr_sum_s = ex_rs1_i + ex_imm_i;
        if (ex_br_op_i == BR_JALR) begin
            target_o = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_o = ex_pc_i + ex_imm_i;
        end
    end

    // Split a taken instruction into a clean redirect or an alignment fault
    always_comb begin
        bad_align_s = (target_o[ALIGN_BITS-1:0] != {ALIGN_BITS{1'b0}});
        if (ex_valid_i && taken_s) begin
            redirect_o = ~bad_align_s;
            misalign_o = bad_align_s;
        end else begin
            redirect_o = 1'b0;
            misalign_o = 1'b0;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator and PC register. Arbitrates trap entry, mret and the
// execute-stage redirect against sequential fetch, and presents the PC to
// instruction fetch over a valid/ready handshake.
module pc_next_unit
    import pc_next_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ex_valid_i,
    input  logic [3:0]       ex_br_op_i,
    input  logic             ex_zero_i,
    input  logic             ex_less_i,
    input  logic             ex_less_u_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_imm_i,
    input  logic [XLEN-1:0]  ex_rs1_i,
    input  logic             trap_req_i,
    input  logic [XLEN-1:0]  trap_vec_i,
    input  logic             mret_req_i,
    input  logic [XLEN-1:0]  mepc_i,
    output logic             if_valid_o,
    input  logic             if_ready_i,
    output logic [XLEN-1:0]  if_pc_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0] INC_PC   = XLEN'(PC_INC);

    logic             ex_redirect_s;
    logic             ex_misalign_s;
    logic [XLEN-1:0]  ex_target_s;
    logic             redirect_s;

    logic [XLEN-1:0]  pc_q,       pc_d;
    logic             valid_q,    valid_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             mis_q,      mis_d;
    logic [XLEN-1:0]  mis_addr_q, mis_addr_d;

    br_resolve #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_br_resolve (
        .ex_valid_i  (ex_valid_i),
        .ex_br_op_i  (ex_br_op_i),
        .ex_zero_i   (ex_zero_i),
        .ex_less_i   (ex_less_i),
        .ex_less_u_i (ex_less_u_i),
        .ex_pc_i     (ex_pc_i),
        .ex_imm_i    (ex_imm_i),
        .ex_rs1_i    (ex_rs1_i),
        .redirect_o  (ex_redirect_s),
        .misalign_o  (ex_misalign_s),
        .target_o    (ex_target_s)
    );

    // Next-state selection: trap > mret > ex redirect > sequential fetch
    always_comb begin
        pc_d       = pc_q;
        valid_d    = 1'b1;
        cnt_d      = cnt_q;
        mis_d      = 1'b0;
        mis_addr_d = mis_addr_q;
        redirect_s = 1'b0;
        if (trap_req_i) begin
            redirect_s = 1'b1;
            pc_d       = trap_vec_i;
            cnt_d      = cnt_q + CNT_W'(1);
        end else if (mret_req_i) begin
            redirect_s = 1'b1;
            pc_d       = mepc_i;
            cnt_d      = cnt_q + CNT_W'(1);
        end else if (ex_redirect_s) begin
            redirect_s = 1'b1;
            pc_d       = ex_target_s;
            cnt_d      = cnt_q + CNT_W'(1);
        end else begin
            // A misaligned target never moves the PC; it is reported next cycle
            if (ex_misalign_s) begin
                mis_d      = 1'b1;
                mis_addr_d = ex_target_s;
            end else begin
                mis_d      = 1'b0;
                mis_addr_d = mis_addr_q;
            end
            if (valid_q && if_ready_i) begin
                pc_d = pc_q + INC_PC;
            end else begin
                pc_d = pc_q;
            end
        end
    end

    // PC, handshake, fault report and counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            mis_q      <= 1'b0;
            mis_addr_q <= {XLEN{1'b0}};
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    // Flush is the only combinational output; reset suppresses any redirect
    assign flush_o         = redirect_s & ~rst_i;
    assign if_pc_o         = pc_q;
    assign if_valid_o      = valid_q;
    assign taken_cnt_o     = cnt_q;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: two instances (ALIGN_BITS=2 with a
// 32-bit counter, ALIGN_BITS=1 with a 3-bit counter) share stimulus and are
// compared every cycle against a behavioural model, plus literal spot checks.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_br_op;
    logic        ex_zero, ex_less, ex_less_u;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        trap_req, mret_req;
    logic [31:0] trap_vec, mepc;
    logic        if_ready;

    logic        if_valid_w [2];
    logic [31:0] if_pc_w    [2];
    logic        flush_w    [2];
    logic        mis_w      [2];
    logic [31:0] maddr_w    [2];
    logic [31:0] cnt0;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;
    logic run_chk = 1'b0;

    // model state per instance
    logic [31:0] m_pc    [2];
    logic        m_valid [2];
    logic [31:0] m_cnt   [2];
    logic        m_mis   [2];
    logic [31:0] m_maddr [2];

    always #5 clk = ~clk;

    pc_next_unit #(.XLEN(32), .RESET_VEC(32'h8000_0000), .ALIGN_BITS(2), .CNT_W(32)) dut0 (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_br_op_i(ex_br_op),
        .ex_zero_i(ex_zero), .ex_less_i(ex_less), .ex_less_u_i(ex_less_u),
        .ex_pc_i(ex_pc), .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1),
        .trap_req_i(trap_req), .trap_vec_i(trap_vec), .mret_req_i(mret_req), .mepc_i(mepc),
        .if_valid_o(if_valid_w[0]), .if_ready_i(if_ready), .if_pc_o(if_pc_w[0]),
        .flush_o(flush_w[0]), .misalign_o(mis_w[0]), .misalign_addr_o(maddr_w[0]),
        .taken_cnt_o(cnt0));

    pc_next_unit #(.XLEN(32), .RESET_VEC(32'h8000_0000), .ALIGN_BITS(1), .CNT_W(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_br_op_i(ex_br_op),
        .ex_zero_i(ex_zero), .ex_less_i(ex_less), .ex_less_u_i(ex_less_u),
        .ex_pc_i(ex_pc), .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1),
        .trap_req_i(trap_req), .trap_vec_i(trap_vec), .mret_req_i(mret_req), .mepc_i(mepc),
        .if_valid_o(if_valid_w[1]), .if_ready_i(if_ready), .if_pc_o(if_pc_w[1]),
        .flush_o(flush_w[1]), .misalign_o(mis_w[1]), .misalign_addr_o(maddr_w[1]),
        .taken_cnt_o(cnt1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // architectural rules
    function automatic logic m_taken(input logic [3:0] op, input logic z, input logic l, input logic lu);
        case (op)
            4'd1, 4'd2: return 1'b1;
            4'd4: return z;
            4'd5: return !z;
            4'd6: return l;
            4'd7: return !l;
            4'd8: return lu;
            4'd9: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target();
        if (ex_br_op == 4'd2) return (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
        else return ex_pc + ex_imm;
    endfunction

    function automatic logic m_aligned(input int k, input logic [31:0] t);
        int unsigned ab = (k == 0) ? 2 : 1;
        return (t % (32'd1 << ab)) == 32'd0;
    endfunction

    function automatic logic m_ex_hit();
        return ex_valid && m_taken(ex_br_op, ex_zero, ex_less, ex_less_u);
    endfunction

    function automatic logic m_flush(input int k);
        if (rst) return 1'b0;
        return trap_req || mret_req || (m_ex_hit() && m_aligned(k, m_target()));
    endfunction

    // behavioural model update on each rising edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [31:0] mask;
            logic [31:0] tgt;
            logic        seq;
            mask = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0007;
            tgt  = m_target();
            seq  = m_valid[k] && if_ready;
            if (rst) begin
                m_pc[k] = 32'h8000_0000; m_valid[k] = 1'b0; m_cnt[k] = 32'd0;
                m_mis[k] = 1'b0; m_maddr[k] = 32'd0;
            end else begin
                m_mis[k] = 1'b0;
                if (trap_req) begin
                    m_pc[k] = trap_vec; m_cnt[k] = (m_cnt[k] + 32'd1) & mask;
                end else if (mret_req) begin
                    m_pc[k] = mepc; m_cnt[k] = (m_cnt[k] + 32'd1) & mask;
                end else if (m_ex_hit() && m_aligned(k, tgt)) begin
                    m_pc[k] = tgt; m_cnt[k] = (m_cnt[k] + 32'd1) & mask;
                end else begin
                    if (m_ex_hit()) begin
                        m_mis[k] = 1'b1; m_maddr[k] = tgt;
                    end
                    if (seq) m_pc[k] = m_pc[k] + 32'd4;
                end
                m_valid[k] = 1'b1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (run_chk) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("if_valid%0d", k), {31'd0, if_valid_w[k]}, {31'd0, m_valid[k]});
                chk($sformatf("if_pc%0d", k), if_pc_w[k], m_pc[k]);
                chk($sformatf("flush%0d", k), {31'd0, flush_w[k]}, {31'd0, m_flush(k)});
                chk($sformatf("misalign%0d", k), {31'd0, mis_w[k]}, {31'd0, m_mis[k]});
                if (m_mis[k]) chk($sformatf("misalign_addr%0d", k), maddr_w[k], m_maddr[k]);
                chk($sformatf("taken_cnt%0d", k), (k == 0) ? cnt0 : {29'd0, cnt1}, m_cnt[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_br_op = 4'd0; ex_zero = 1'b0; ex_less = 1'b0; ex_less_u = 1'b0;
        trap_req = 1'b0; mret_req = 1'b0;
    endtask

    task automatic set_ex(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm);
        ex_valid = 1'b1; ex_br_op = op; ex_pc = pc; ex_imm = imm;
    endtask

    initial begin
        rst = 1'b1; if_ready = 1'b1; idle();
        ex_pc = 32'd0; ex_imm = 32'd0; ex_rs1 = 32'd0;
        trap_vec = 32'h8000_0400; mepc = 32'h8000_0200;
        tick();
        run_chk = 1'b1;
        tick();
        chk("rst_pc", if_pc_w[0], 32'h8000_0000);
        chk("rst_valid", {31'd0, if_valid_w[0]}, 32'd0);

        // reset release and sequential fetch
        rst = 1'b0;
        tick();
        chk("first_pc", if_pc_w[0], 32'h8000_0000);
        chk("first_valid", {31'd0, if_valid_w[0]}, 32'd1);
        tick(); chk("seq_4", if_pc_w[0], 32'h8000_0004);
        tick(); chk("seq_8", if_pc_w[0], 32'h8000_0008);
        tick(); chk("seq_c", if_pc_w[0], 32'h8000_000C);
        tick(); chk("seq_10", if_pc_w[0], 32'h8000_0010);

        // stall
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_pc", if_pc_w[0], 32'h8000_0010);
            chk("stall_valid", {31'd0, if_valid_w[0]}, 32'd1);
        end

        // BEQ taken and not taken
        if_ready = 1'b1;
        set_ex(4'd4, 32'h8000_0020, 32'hFFFF_FFF0); ex_zero = 1'b1;
        #1 chk("beq_flush", {31'd0, flush_w[0]}, 32'd1);
        tick();
        chk("beq_pc", if_pc_w[0], 32'h8000_0010);
        chk("beq_cnt", cnt0, 32'd1);
        ex_zero = 1'b0;
        #1 chk("beq_nt_flush", {31'd0, flush_w[0]}, 32'd0);
        tick();
        chk("beq_nt_pc", if_pc_w[0], 32'h8000_0014);

        // JALR with bit0 cleared; misaligned for ALIGN_BITS=2 only
        if_ready = 1'b0;
        set_ex(4'd2, 32'h8000_0014, 32'd2); ex_rs1 = 32'h8000_0101;
        #1 chk("jalr_flush0", {31'd0, flush_w[0]}, 32'd0);
        chk("jalr_flush1", {31'd0, flush_w[1]}, 32'd1);
        tick();
        chk("jalr_mis0", {31'd0, mis_w[0]}, 32'd1);
        chk("jalr_maddr0", maddr_w[0], 32'h8000_0102);
        chk("jalr_pc0", if_pc_w[0], 32'h8000_0014);
        chk("jalr_pc1", if_pc_w[1], 32'h8000_0102);
        idle(); if_ready = 1'b1;
        tick();
        chk("mis_pulse_end", {31'd0, mis_w[0]}, 32'd0);

        // BLTU uses the unsigned flag; BGE taken on !less
        set_ex(4'd8, 32'h8000_0040, 32'd8); ex_less = 1'b1; ex_less_u = 1'b0;
        #1 chk("bltu_flush", {31'd0, flush_w[0]}, 32'd0);
        tick();
        ex_br_op = 4'd7; ex_less = 1'b0;
        #1 chk("bge_flush", {31'd0, flush_w[0]}, 32'd1);
        tick();
        chk("bge_pc", if_pc_w[0], 32'h8000_0048);

        // trap + mret + taken BNE: trap wins, counted once
        ex_br_op = 4'd5; ex_zero = 1'b0; trap_req = 1'b1; mret_req = 1'b1;
        tick();
        chk("trap_pc", if_pc_w[0], 32'h8000_0400);
        chk("trap_cnt", cnt0, 32'd3);
        idle(); rst = 1'b1;
        tick();
        chk("rst2_pc", if_pc_w[0], 32'h8000_0000);
        chk("rst2_cnt", cnt0, 32'd0);
        rst = 1'b0;
        tick();

        // trap masks a misaligned JAL
        set_ex(4'd1, 32'h8000_0000, 32'd1); trap_req = 1'b1;
        tick();
        chk("trap_mis0", {31'd0, mis_w[0]}, 32'd0);
        chk("trap_mis1", {31'd0, mis_w[1]}, 32'd0);
        idle(); mret_req = 1'b1;
        tick();
        chk("mret_pc", if_pc_w[0], 32'h8000_0200);
        idle(); ex_br_op = 4'd1;
        #1 chk("novalid_flush", {31'd0, flush_w[0]}, 32'd0);
        tick();

        // counter wrap on the 3-bit instance (2 + 6 = 8 -> 0)
        for (int i = 0; i < 6; i++) begin
            set_ex(4'd1, 32'h8000_0100, 32'(4 * i));
            tick();
        end
        chk("wrap_cnt1", {29'd0, cnt1}, 32'd0);
        chk("wrap_cnt0", cnt0, 32'd8);

        // mixed pseudo-random traffic checked by the model
        for (int i = 0; i < 60; i++) begin
            ex_valid  = ($urandom_range(3) != 0);
            ex_br_op  = 4'($urandom_range(15));
            ex_zero   = 1'($urandom_range(1));
            ex_less   = 1'($urandom_range(1));
            ex_less_u = 1'($urandom_range(1));
            ex_pc     = 32'h8000_0000 + (32'($urandom_range(255)) << 2);
            ex_imm    = 32'($urandom_range(63)) << (($urandom_range(3) == 0) ? 0 : 2);
            ex_rs1    = 32'h8000_1000 + 32'($urandom_range(255));
            trap_req  = ($urandom_range(15) == 0);
            mret_req  = ($urandom_range(15) == 0);
            if_ready  = ($urandom_range(3) != 0);
            rst       = ($urandom_range(31) == 0);
            tick();
        end
        rst = 1'b0; idle();
        tick();
        run_chk = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
